ps2_kbd_rx: RTL and testbench
=============================

// Module: ps2_kbd_rx
// PURPOSE
//  PS/2 keyboard receiver; upstream producer of the 10-bit ps2kb_key word read by the
//  memory-mapped I/O bus at 0xD0000000. Filters and synchronises ps2_clk/ps2_data,
//  deframes 11-bit device->host frames and folds E0/F0 prefixes into one key event.
//  The last key event stays on ps2kb_key until the next event replaces it (CPU polls).
// PARAMETERS
//  FILTER_LEN   8       consecutive equal clk samples needed before filtered ps2_clk changes
//  TIMEOUT_CYC  100000  clk cycles without a filtered falling edge before a partial frame aborts
// PORTS
//  clk        in   1   system clock; sole clock domain
//  rst        in   1   asynchronous, active-low reset
//  ps2_clk    in   1   raw PS/2 clock pin (asynchronous)
//  ps2_data   in   1   raw PS/2 data pin (asynchronous)
//  ps2kb_key  out  10  {released, extended, scancode[7:0]}; held between events
//  key_strobe out  1   one-cycle pulse when ps2kb_key is updated
//  frame_err  out  1   one-cycle pulse on any frame abort (start/stop/parity/timeout)
// BEHAVIOUR
//  - Reset (rst=0, async): ps2kb_key=10'h0, key_strobe=0, frame_err=0, FSM=IDLE,
//    prefix flags ext/brk=0, bit counter=0, timeout counter=0, filter state=1 (idle high).
//  - Input path: 2-FF synchroniser on both pins; filtered ps2_clk toggles only after
//    FILTER_LEN identical synchronised samples; fall = 1-cycle pulse on filtered 1->0.
//    Data sampled from synchronised ps2_data in the cycle fall is high.
//  - Frame FSM (advances only on fall unless timeout):
//    IDLE:   data=0 -> DATA (bitcnt=0); data=1 -> stay IDLE, no error (spurious edge).
//    DATA:   shift in LSB first; after bit 7 (bitcnt=7) -> PARITY.
//    PARITY: capture parity bit -> STOP.
//    STOP:   data=1 and parity check passes -> byte_done pulse, IDLE; else frame_err, IDLE.
//  - Parity: odd over data[7:0]+parity bit (see CONFIGURATION).
//  - Timeout: counter clears on every fall and in IDLE; if FSM!=IDLE and counter reaches
//    TIMEOUT_CYC-1 -> FSM=IDLE, frame_err pulse, ext/brk cleared. Counter saturates.
//  - Decoder on byte_done: E0 -> ext=1; F0 -> brk=1; AA/FA/FE/E1 -> discarded, flags kept;
//    any other byte B -> ps2kb_key={brk,ext,B}, key_strobe=1, ext=brk=0.
//  - Latency: ps2kb_key/key_strobe update exactly 2 clk cycles after the fall pulse of the
//    stop bit (byte_done registered at +1, key register at +2).
//  - frame_err on bad frame also clears ext/brk (a split E0 F0 xx sequence is dropped whole).
//  - Simultaneous timeout and fall in the same cycle: fall wins (counter cleared, FSM advances).
//  - ps2kb_key is never cleared except by reset; repeated identical events still strobe.
//  - rst asserted mid-frame: partial byte and prefix flags lost; first full frame after
//    release decodes normally.
// CONFIGURATION
//  PS2_PARITY_CHK_EN defined: STOP rejects frames with even parity (frame_err, no byte).
//  Undefined: parity bit captured but ignored; only start/stop/timeout cause frame_err.
// STRUCTURE
//  - Shared package ps2_pkg: FSM state encoding (IDLE/DATA/PARITY/STOP), byte constants
//    PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_RSND=8'hFE, PS2_PAUSE=8'hE1.
//  - Sub-module ps2_filter: synchroniser + glitch filter + falling-edge detect for ps2_clk,
//    synchroniser for ps2_data; parameter FILTER_LEN. Deframer and decoder stay in top.
// TESTING
//  1 Frame 0x1C (A make), good parity/stop -> ps2kb_key=10'h01C, key_strobe 1 cycle, +2 clk.
//  2 Bytes F0,1C -> single strobe after 2nd byte, ps2kb_key=10'h21C; no strobe after F0.
//  3 Bytes E0,F0,75 -> ps2kb_key=10'h375; then 0x75 alone -> 10'h075 (flags cleared).
//  4 Frame 0x1C with wrong parity -> with PS2_PARITY_CHK_EN: frame_err pulse, ps2kb_key
//    unchanged; without: ps2kb_key=10'h01C. Stop bit=0 -> frame_err in both builds.
//  5 Send start+4 bits then hold ps2_clk high TIMEOUT_CYC cycles -> frame_err, FSM IDLE;
//    following good frame 0x29 -> 10'h029. Glitch < FILTER_LEN cycles on ps2_clk -> no bit.
//  6 Assert rst mid-frame after E0 -> outputs 0; next frame 0x1C -> 10'h01C (ext not kept).

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared frame-FSM state encoding and PS/2 byte constants.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_RSND  = 8'hFE;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Device housekeeping bytes that never form a key event.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RSND) || (b == PS2_PAUSE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_filter.sv
// ============================================================================
//  Module   : ps2_filter
//  Purpose  : Pin synchronisers, ps2_clk glitch filter and falling-edge pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fall,
    output logic o_data
);

    localparam int               c_cw      = $clog2(FILTER_LEN + 1);
    localparam logic [c_cw-1:0]  c_cnt_max = c_cw'(FILTER_LEN - 1);

    logic            r_clk_meta;
    logic            r_clk_sync;
    logic            r_dat_meta;
    logic            r_dat_sync;
    logic            r_filt;
    logic            r_filt_d;
    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= i_ps2_data;
            r_dat_sync <= r_dat_meta;
            r_filt_d   <= r_filt;
            // The FILTER_LEN-th consecutive differing sample flips the filtered level.
            if (r_clk_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_filt <= r_clk_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_fall = r_filt_d & ~r_filt;
    assign o_data = r_dat_sync;

endmodule

`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
// ============================================================================
//  Module   : ps2_kbd_rx
//  Purpose  : PS/2 keyboard receiver: deframes device->host bytes and folds
//             E0/F0 prefixes into a held {released, extended, scancode} word.
//             Define PS2_PARITY_CHK_EN to reject frames with bad odd parity.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] ps2kb_key,
    output logic       key_strobe,
    output logic       frame_err
);

    localparam int              c_tw     = $clog2(TIMEOUT_CYC);
    localparam logic [c_tw-1:0] c_to_max = c_tw'(TIMEOUT_CYC - 1);

    logic            w_fall;
    logic            w_data;
    ps2_state_t      r_state;
    ps2_state_t      w_state_nxt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic [c_tw-1:0] r_to_cnt;
    logic            r_byte_done;
    logic            r_frame_err;
    logic            r_ext;
    logic            r_brk;
    logic [9:0]      r_key;
    logic            r_key_strobe;
    logic            w_shift_en;
    logic            w_bit_clr;
    logic            w_done;
    logic            w_err;
    logic            w_timeout;
    logic            w_parity_ok;

    ps2_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_fall     (w_fall),
        .o_data     (w_data)
    );

`ifdef PS2_PARITY_CHK_EN
    logic r_parity;
    logic w_par_cap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_parity <= 1'b0;
        else if (w_par_cap) r_parity <= w_data;
    end

    assign w_par_cap   = w_fall && (r_state == ST_PARITY);
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == c_to_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // A fall in the same cycle as the timeout takes priority.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_bit_clr   = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_data) begin
                        w_state_nxt = ST_DATA;
                        w_bit_clr   = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                end
                ST_PARITY: begin
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (w_data && w_parity_ok) w_done = 1'b1;
                    else                       w_err  = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_to_cnt    <= '0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_done <= w_done;
            r_frame_err <= w_err;
            if (w_bit_clr) begin
                r_bitcnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shift  <= {w_data, r_shift[7:1]};
            end
            if (w_fall || (r_state == ST_IDLE)) r_to_cnt <= '0;
            else if (r_to_cnt != c_to_max)      r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // r_shift stays stable while r_byte_done is high: the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_key        <= 10'h000;
            r_key_strobe <= 1'b0;
        end else begin
            r_key_strobe <= 1'b0;
            if (r_frame_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_byte_done) begin
                if (r_shift == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else if (!is_discard(r_shift)) begin
                    r_key        <= {r_brk, r_ext, r_shift};
                    r_key_strobe <= 1'b1;
                    r_ext        <= 1'b0;
                    r_brk        <= 1'b0;
                end
            end
        end
    end

    assign ps2kb_key  = r_key;
    assign key_strobe = r_key_strobe;
    assign frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
// ============================================================================
//  Module   : tb_ps2_kbd_rx
//  Purpose  : Directed self-checking bench for ps2_kbd_rx.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_kbd_rx;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] ps2kb_key;
    logic       key_strobe;
    logic       frame_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_strobe = 0;
    int         n_err    = 0;
    logic [9:0] exp_key;

    ps2_kbd_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2kb_key  (ps2kb_key),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles, so a stretched pulse shows up as a count above one.
    always @(negedge clk) begin
        if (key_strobe) n_strobe = n_strobe + 1;
        if (frame_err)  n_err    = n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                               input logic stop);
        return {stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(20);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0, 1'b1), 11);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    task automatic clr_cnt();
        n_strobe = 0;
        n_err    = 0;
    endtask

    initial begin
        // Reset state
        wait_cyc(5);
        chk("rst_key", 32'(ps2kb_key), 32'h000);
        chk("rst_strobe", 32'(key_strobe), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        rst = 1'b1;
        wait_cyc(10);
        clr_cnt();

        // A make
        send_byte(8'h1C);
        chk("make_key", 32'(ps2kb_key), 32'h01C);
        chk("make_strobe", 32'(n_strobe), 32'd1);
        chk("make_err", 32'(n_err), 32'd0);

        // Break prefix
        clr_cnt();
        send_byte(8'hF0);
        chk("f0_nostrobe", 32'(n_strobe), 32'd0);
        send_byte(8'h1C);
        chk("brk_key", 32'(ps2kb_key), 32'h21C);
        chk("brk_strobe", 32'(n_strobe), 32'd1);

        // Extended break, then plain key with flags cleared
        clr_cnt();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("extbrk_key", 32'(ps2kb_key), 32'h375);
        chk("extbrk_strobe", 32'(n_strobe), 32'd1);
        clr_cnt();
        send_byte(8'h75);
        chk("plain_key", 32'(ps2kb_key), 32'h075);
        chk("plain_strobe", 32'(n_strobe), 32'd1);

        // Bad parity
        clr_cnt();
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
        wait_cyc(10);
`ifdef PS2_PARITY_CHK_EN
        exp_key = 10'h075;
        chk("par_err", 32'(n_err), 32'd1);
        chk("par_strobe", 32'(n_strobe), 32'd0);
`else
        exp_key = 10'h01C;
        chk("par_err", 32'(n_err), 32'd0);
        chk("par_strobe", 32'(n_strobe), 32'd1);
`endif
        chk("par_key", 32'(ps2kb_key), 32'(exp_key));

        // Bad stop bit
        clr_cnt();
        send_bits(make_frame(8'h29, 1'b0, 1'b0), 11);
        ps2_data = 1'b1;
        wait_cyc(10);
        chk("stop_err", 32'(n_err), 32'd1);
        chk("stop_strobe", 32'(n_strobe), 32'd0);
        chk("stop_key", 32'(ps2kb_key), 32'(exp_key));

        // Frame error drops a pending E0 prefix
        clr_cnt();
        send_byte(8'hE0);
        send_bits(make_frame(8'h12, 1'b0, 1'b0), 11);
        ps2_data = 1'b1;
        wait_cyc(10);
        send_byte(8'h1C);
        chk("split_key", 32'(ps2kb_key), 32'h01C);
        chk("split_err", 32'(n_err), 32'd1);
        chk("split_strobe", 32'(n_strobe), 32'd1);

        // Timeout on partial frame, then recovery
        clr_cnt();
        send_bits(make_frame(8'h55, 1'b0, 1'b1), 5);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT_CYC + 100);
        chk("to_err", 32'(n_err), 32'd1);
        chk("to_strobe", 32'(n_strobe), 32'd0);
        clr_cnt();
        send_byte(8'h29);
        chk("to_recover_key", 32'(ps2kb_key), 32'h029);
        chk("to_recover_err", 32'(n_err), 32'd0);

        // Short glitch on ps2_clk must not register as a start bit
        clr_cnt();
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        ps2_clk = 1'b1;
        wait_cyc(20);
        ps2_data = 1'b1;
        wait_cyc(20);
        send_byte(8'h1C);
        chk("glitch_key", 32'(ps2kb_key), 32'h01C);
        chk("glitch_err", 32'(n_err), 32'd0);
        chk("glitch_strobe", 32'(n_strobe), 32'd1);

        // Discarded bytes keep pending prefix
        clr_cnt();
        send_byte(8'hE0);
        send_byte(8'hAA);
        send_byte(8'h75);
        chk("disc_key", 32'(ps2kb_key), 32'h175);
        chk("disc_strobe", 32'(n_strobe), 32'd1);

        // Repeated identical event still strobes
        send_byte(8'h75);
        clr_cnt();
        send_byte(8'h75);
        chk("repeat_key", 32'(ps2kb_key), 32'h075);
        chk("repeat_strobe", 32'(n_strobe), 32'd1);

        // Reset mid-frame after E0
        send_byte(8'hE0);
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 4);
        rst = 1'b0;
        wait_cyc(3);
        chk("midrst_key", 32'(ps2kb_key), 32'h000);
        chk("midrst_strobe", 32'(key_strobe), 32'h0);
        chk("midrst_err", 32'(frame_err), 32'h0);
        ps2_data = 1'b1;
        rst = 1'b1;
        wait_cyc(10);
        clr_cnt();
        send_byte(8'h1C);
        chk("postrst_key", 32'(ps2kb_key), 32'h01C);
        chk("postrst_strobe", 32'(n_strobe), 32'd1);
        chk("postrst_err", 32'(n_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
